// File: rtl/stage_preif.sv
// Pre-fetch stage: owns the fetch PC, issues instruction SRAM reads and offers {pc, valid} to IF.
// Optional PC alignment check (address error on fetch) enabled by defining PREIF_ADEF_EN.
module stage_preif #(
  parameter logic [31:0] RESET_PC = 32'h1c000000,
  parameter int unsigned PC_STEP  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        allowout,
  output logic        validout,
  output logic [31:0] output_pc,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        ex_taken,
  input  logic [31:0] ex_entry,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_we,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic        output_adef
);

  localparam int unsigned PC_W = 32;
  localparam int unsigned BE_W = 4;

  logic            valid_q, valid_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            redirect;
  logic            load;
  logic            pc_misaligned;
  logic            next_misaligned;
  logic [PC_W-1:0] nextpc;
  logic [PC_W-1:0] seq_pc;

  // Sequential successor; a misaligned PC parks until a redirect when the check is on.
  always_comb begin
    seq_pc = pc_q + PC_W'(PC_STEP);
`ifdef PREIF_ADEF_EN
    if (pc_q[1:0] != 2'b00) begin
      seq_pc = pc_q;
    end
`endif
  end

  // Next fetch address, exception beating branch beating sequential.
  always_comb begin
    redirect = ex_taken | br_taken;
    load     = ~valid_q | allowout | redirect;
    nextpc   = RESET_PC;
    if (ex_taken) begin
      nextpc = ex_entry;
    end else if (br_taken) begin
      nextpc = br_target;
    end else if (valid_q) begin
      nextpc = seq_pc;
    end
  end

`ifdef PREIF_ADEF_EN
  assign pc_misaligned   = valid_q & (pc_q[1:0] != 2'b00);
  assign next_misaligned = (nextpc[1:0] != 2'b00);
`else
  assign pc_misaligned   = 1'b0;
  assign next_misaligned = 1'b0;
`endif

  // State update only when a new PC is loaded; stalls hold pc and valid.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    if (load) begin
      pc_d    = nextpc;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  // An offered PC is wrong-path during any redirect, so hide it from IF.
  assign validout        = valid_q & ~redirect;
  assign output_pc       = pc_q;
  assign output_adef     = pc_misaligned;
  assign inst_sram_en    = load & rst & ~next_misaligned;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_we    = BE_W'(0);
  assign inst_sram_wdata = PC_W'(0);

endmodule
